// File: rtl/tpu_pkg.sv
// Shared state encoding, array geometry and capture-window helpers for the
// TPU job controller (optional perf counter: TPU_JOB_CTRL_PERF_EN).
package tpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DRAIN  = 3'd4
  } tpu_state_e;

  localparam int SA_DIM    = 3;
  localparam int RESULTS   = 9;
  localparam int FLUSH_END = 7;
  localparam int STEP_W    = 3;
  localparam int IDX_W     = 4;

  // Column c (0-based) is sampled at steps CAP_FIRST+c .. CAP_FIRST+c+CAP_LEN-1
  // into buffer entries c*SA_DIM .. c*SA_DIM+CAP_LEN-1.
  localparam int CAP_FIRST = 1;
  localparam int CAP_LEN   = SA_DIM;

  function automatic logic cap_hit(input int col, input logic [STEP_W-1:0] s);
    int lo;
    lo = CAP_FIRST + col;
    return (int'(s) >= lo) && (int'(s) < lo + CAP_LEN);
  endfunction

  function automatic logic [IDX_W-1:0] cap_idx(input int col, input logic [STEP_W-1:0] s);
    return IDX_W'(col * SA_DIM + int'(s) - (CAP_FIRST + col));
  endfunction

endpackage

// File: rtl/tpu_result_buf.sv
// Nine-entry result buffer: one write port per array column, one read port
// addressed by the drain index.
module tpu_result_buf
  import tpu_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SA_DIM-1:0]               wr_en_i,
  input  logic [SA_DIM-1:0][IDX_W-1:0]    wr_idx_i,
  input  logic [SA_DIM-1:0][ACC_W-1:0]    wr_data_i,
  input  logic [IDX_W-1:0]                rd_idx_i,
  output logic [ACC_W-1:0]                rd_data_o
);

  logic [RESULTS-1:0][ACC_W-1:0] mem_q;

  // Capture windows never overlap on an entry, so column writes never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else begin
      for (int c = 0; c < SA_DIM; c++) begin
        if (wr_en_i[c] && (wr_idx_i[c] < IDX_W'(RESULTS))) begin
          mem_q[wr_idx_i[c]] <= wr_data_i[c];
        end
      end
    end
  end

  assign rd_data_o = (rd_idx_i < IDX_W'(RESULTS)) ? mem_q[rd_idx_i] : '0;

endmodule

// File: rtl/tpu_job_ctrl.sv
// Job controller for a 3x3 systolic array: load weights, stream rows, flush,
// then drain nine results. Optional stall counter: TPU_JOB_CTRL_PERF_EN.
module tpu_job_ctrl
  import tpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [SA_DIM*SA_DIM*DATA_W-1:0]   cmd_wgt,
  input  logic                              row_valid,
  output logic                              row_ready,
  input  logic [SA_DIM*DATA_W-1:0]          row_data,
  output logic                              sa_en,
  output logic [SA_DIM*SA_DIM*DATA_W-1:0]   sa_w,
  output logic [SA_DIM*DATA_W-1:0]          sa_in,
  input  logic [ACC_W-1:0]                  sa_out1,
  input  logic [ACC_W-1:0]                  sa_out2,
  input  logic [ACC_W-1:0]                  sa_out3,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [ACC_W-1:0]                  res_data,
  output logic                              res_last,
  output logic                              busy,
  output logic                              done,
`ifdef TPU_JOB_CTRL_PERF_EN
  output logic [15:0]                       stall_cnt,
`endif
  output tpu_state_e                        dbg_state
);

  // Handshakes (cmd, row, res): a transfer happens in a cycle where valid and
  // ready are both high; the sender holds valid and payload until then.

  tpu_state_e                      state_q, state_d;
  logic [STEP_W-1:0]               step_q, step_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [SA_DIM*SA_DIM*DATA_W-1:0] wgt_q, wgt_d;

  logic [SA_DIM-1:0]               cap_en;
  logic [SA_DIM-1:0][IDX_W-1:0]    cap_idx_v;
  logic [SA_DIM-1:0][ACC_W-1:0]    cap_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      idx_q   <= '0;
      wgt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      wgt_q   <= wgt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    idx_d     = idx_q;
    wgt_d     = wgt_q;
    cmd_ready = 1'b0;
    row_ready = 1'b0;
    sa_en     = 1'b0;
    sa_in     = '0;
    res_valid = 1'b0;
    res_last  = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          wgt_d   = cmd_wgt;
          step_d  = '0;
          idx_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        step_d  = '0;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        row_ready = (step_q < STEP_W'(SA_DIM));
        if (row_valid && row_ready) begin
          sa_en  = 1'b1;
          sa_in  = row_data;
          step_d = step_q + 1'b1;
          if (step_q == STEP_W'(SA_DIM - 1)) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Zeros push the last partial sums out of the array.
        sa_en  = 1'b1;
        step_d = step_q + 1'b1;
        if (step_q == STEP_W'(FLUSH_END - 1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        res_valid = 1'b1;
        res_last  = (idx_q == IDX_W'(RESULTS - 1));
        if (res_ready) begin
          idx_d = idx_q + 1'b1;
          if (res_last) begin
            done    = 1'b1;
            idx_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The step value seen here is the one before this cycle's increment.
  always_comb begin
    cap_en    = '0;
    cap_idx_v = '0;
    for (int c = 0; c < SA_DIM; c++) begin
      cap_en[c]    = sa_en && cap_hit(c, step_q);
      cap_idx_v[c] = cap_idx(c, step_q);
    end
  end

  assign cap_data = {sa_out3, sa_out2, sa_out1};

  tpu_result_buf #(.ACC_W(ACC_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (cap_en),
    .wr_idx_i  (cap_idx_v),
    .wr_data_i (cap_data),
    .rd_idx_i  (idx_q),
    .rd_data_o (res_data)
  );

  assign sa_w      = wgt_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

`ifdef TPU_JOB_CTRL_PERF_EN
  logic [15:0] stall_cnt_q;
  logic        stall_ev;

  assign stall_ev = ((state_q == ST_STREAM) && !row_valid) ||
                    ((state_q == ST_DRAIN) && !res_ready);

  always_ff @(posedge clk) begin
    if (rst || (cmd_valid && cmd_ready)) begin
      stall_cnt_q <= '0;
    end else if (stall_ev && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tpu_job_ctrl.sv
// Bench for tpu_job_ctrl with a behavioural 3x3 array model and a result
// scoreboard; define TPU_JOB_CTRL_PERF_EN to include the stall counter test.
module tb_tpu_job_ctrl;
  import tpu_pkg::*;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int W9     = 9 * DATA_W;
  localparam int W3     = 3 * DATA_W;

  typedef logic [2:0][W3-1:0] rows_t;

  logic              clk, rst;
  logic              cmd_valid, cmd_ready;
  logic [W9-1:0]     cmd_wgt;
  logic              row_valid, row_ready;
  logic [W3-1:0]     row_data;
  logic              sa_en;
  logic [W9-1:0]     sa_w;
  logic [W3-1:0]     sa_in;
  logic [ACC_W-1:0]  sa_out1, sa_out2, sa_out3;
  logic              res_valid, res_ready;
  logic [ACC_W-1:0]  res_data;
  logic              res_last, busy, done;
  tpu_state_e        dbg_state;
`ifdef TPU_JOB_CTRL_PERF_EN
  logic [15:0]       stall_cnt;
`endif

  tpu_job_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wgt(cmd_wgt),
    .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .sa_en(sa_en), .sa_w(sa_w), .sa_in(sa_in),
    .sa_out1(sa_out1), .sa_out2(sa_out2), .sa_out3(sa_out3),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .busy(busy), .done(done),
`ifdef TPU_JOB_CTRL_PERF_EN
    .stall_cnt(stall_cnt),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  int cyc;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- array model ----------------
  bit    stub_mode;
  int    tb_s;
  rows_t hist;

  function automatic logic [ACC_W-1:0] arr_out(input int n, input int s, input bit stub,
                                               input logic [W9-1:0] w, input rows_t h);
    int acc;
    int r;
    acc = 0;
    r   = s - n;
    if (stub) acc = 16 * n + s;
    else if (r >= 0 && r < 3)
      for (int k = 0; k < 3; k++)
        acc += int'(w[(k*3+n-1)*DATA_W +: DATA_W]) * int'(h[r][k*DATA_W +: DATA_W]);
    return acc[ACC_W-1:0];
  endfunction

  always @(posedge clk) begin
    if (rst || (cmd_valid && cmd_ready)) begin
      tb_s <= 0;
    end else if (sa_en) begin
      if (tb_s < 3) hist[tb_s] <= sa_in;
      tb_s <= tb_s + 1;
    end
  end

  assign sa_out1 = arr_out(1, tb_s, stub_mode, sa_w, hist);
  assign sa_out2 = arr_out(2, tb_s, stub_mode, sa_w, hist);
  assign sa_out3 = arr_out(3, tb_s, stub_mode, sa_w, hist);

  // ---------------- scoreboard state ----------------
  logic [ACC_W-1:0] exp_q[$];
  int checks, failures;
  int acc_edge, done_edge, wgt_moved, rdy_mid, gap_en, hs_bad;
  int xfers, last_cnt, done_cnt, unstable, last_bad;
  bit rdy_after;
  logic [W9-1:0] cur_wgt;
  logic [15:0]   stall_at_done;

  function automatic logic [W9-1:0] rand_wgt();
    logic [W9-1:0] w;
    for (int k = 0; k < 9; k++) w[k*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 63));
    return w;
  endfunction

  function automatic rows_t rand_rows();
    rows_t r;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < 3; k++) r[i][k*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 63));
    return r;
  endfunction

  task automatic mon();
    if (sa_w !== cur_wgt) wgt_moved++;
    if (cmd_ready !== 1'b0) rdy_mid++;
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle (or about to accept); returns at the
  // negedge following the final result transfer.
  task automatic drive_job(input logic [W9-1:0] wgt, input rows_t rows, input int gap,
                           input int n_stall, input bit stub, input bit keep_cmd,
                           input logic [W9-1:0] next_wgt);
    int n;
    int acc;
    int stalls_left;
    bit stalled_prev, holding;
    logic [ACC_W-1:0] held, exp_v;
    for (int j = 0; j < 3; j++)
      for (int r = 0; r < 3; r++) begin
        acc = 0;
        if (stub) acc = 16 * (j + 1) + (j + 1 + r);
        else
          for (int k = 0; k < 3; k++)
            acc += int'(wgt[(k*3+j)*DATA_W +: DATA_W]) * int'(rows[r][k*DATA_W +: DATA_W]);
        exp_q.push_back(acc[ACC_W-1:0]);
      end
    stub_mode = stub;
    cur_wgt   = wgt;
    cmd_wgt   = wgt;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!cmd_ready) begin failures++; $display("FAIL cmd_accept_timeout got=%0d exp=1", cmd_ready); end
    acc_edge = cyc + 1;
    @(negedge clk);
    if (keep_cmd) cmd_wgt = next_wgt; else cmd_valid = 1'b0;
    wgt_moved = 0; rdy_mid = 0; gap_en = 0; hs_bad = 0; xfers = 0;
    last_cnt = 0; done_cnt = 0; unstable = 0; last_bad = 0; stall_at_done = '0;
    for (int r = 0; r < 3; r++) begin
      row_valid = 1'b1;
      row_data  = rows[r];
      #1;
      n = 0;
      while (!row_ready && n < 50) begin mon(); @(negedge clk); n++; end
      if (sa_en !== 1'b1 || sa_in !== rows[r]) hs_bad++;
      mon();
      @(negedge clk);
      row_valid = 1'b0;
      row_data  = '0;
      #1;
      if (r == 0)
        repeat (gap) begin
          if (sa_en !== 1'b0) gap_en++;
          mon();
          @(negedge clk);
        end
    end
    res_ready = 1'b0;
    n = 0;
    while (!res_valid && n < 100) begin mon(); @(negedge clk); n++; end
    stalls_left = n_stall; stalled_prev = 0; holding = 0; n = 0;
    while (xfers < 9 && n < 200) begin
      if (holding && res_data !== held) unstable++;
      res_ready = !(stalls_left > 0 && !stalled_prev);
      #1;
      if (done === 1'b1) begin
        done_cnt++;
        done_edge = cyc + 1;
`ifdef TPU_JOB_CTRL_PERF_EN
        stall_at_done = stall_cnt;
`endif
      end
      if (!res_ready) begin
        held = res_data; holding = 1; stalls_left--; stalled_prev = 1;
      end else begin
        holding = 0; stalled_prev = 0;
        if (res_valid) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++; $display("FAIL sb_underflow got=%0d exp=none", res_data);
          end else begin
            exp_v = exp_q.pop_front();
            if (res_data !== exp_v) begin
              failures++; $display("FAIL sb_res_data idx=%0d got=%0d exp=%0d", xfers, res_data, exp_v);
            end
          end
          if (res_last === 1'b1) last_cnt++;
          if (res_last !== (xfers == 8)) last_bad++;
          xfers++;
        end
      end
      mon();
      @(negedge clk);
      n++;
    end
    res_ready = 1'b0;
    rdy_after = cmd_ready;
    checks++;
    if (xfers != 9) begin failures++; $display("FAIL drain_timeout got=%0d exp=9", xfers); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 9;
    if (cmd_ready !== 1'b1)     begin failures++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
    if (row_ready !== 1'b0)     begin failures++; $display("FAIL rst_row_ready got=%b exp=0", row_ready); end
    if (busy !== 1'b0)          begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (res_valid !== 1'b0)     begin failures++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
    if (res_last !== 1'b0)      begin failures++; $display("FAIL rst_res_last got=%b exp=0", res_last); end
    if (sa_en !== 1'b0)         begin failures++; $display("FAIL rst_sa_en got=%b exp=0", sa_en); end
    if (sa_in !== '0)           begin failures++; $display("FAIL rst_sa_in got=%h exp=0", sa_in); end
    if (sa_w !== '0)            begin failures++; $display("FAIL rst_sa_w got=%h exp=0", sa_w); end
    if (dbg_state !== ST_IDLE)  begin failures++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
`ifdef TPU_JOB_CTRL_PERF_EN
    checks++;
    if (stall_cnt !== 16'd0)    begin failures++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
    rst = 1'b0;
    @(negedge clk);
    checks += 3;
    if (cmd_ready !== 1'b1)     begin failures++; $display("FAIL post_rst_cmd_ready got=%b exp=1", cmd_ready); end
    if (row_ready !== 1'b0)     begin failures++; $display("FAIL post_rst_row_ready got=%b exp=0", row_ready); end
    if (done !== 1'b0)          begin failures++; $display("FAIL post_rst_done got=%b exp=0", done); end
  endtask

  task automatic test_ones();
    drive_job({9{8'd1}}, {3{24'h010101}}, 0, 0, 1'b0, 1'b0, '0);
    checks += 7;
    if (done_edge - acc_edge != 17) begin failures++; $display("FAIL ones_latency got=%0d exp=17", done_edge - acc_edge); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL ones_leftover got=%0d exp=0", exp_q.size()); end
    if (last_cnt != 1 || last_bad != 0) begin failures++; $display("FAIL ones_res_last got=%0d/%0d exp=1/0", last_cnt, last_bad); end
    if (done_cnt != 1) begin failures++; $display("FAIL ones_done_pulses got=%0d exp=1", done_cnt); end
    if (hs_bad != 0) begin failures++; $display("FAIL ones_row_handshake got=%0d exp=0", hs_bad); end
    if (wgt_moved != 0 || rdy_mid != 0) begin failures++; $display("FAIL ones_wgt_or_ready got=%0d/%0d exp=0/0", wgt_moved, rdy_mid); end
    if (rdy_after !== 1'b1) begin failures++; $display("FAIL ones_ready_after_done got=%b exp=1", rdy_after); end
  endtask

  task automatic test_stub();
    drive_job(rand_wgt(), rand_rows(), 0, 0, 1'b1, 1'b0, '0);
    checks += 2;
    if (exp_q.size() != 0) begin failures++; $display("FAIL stub_leftover got=%0d exp=0", exp_q.size()); end
    if (done_edge - acc_edge != 17) begin failures++; $display("FAIL stub_latency got=%0d exp=17", done_edge - acc_edge); end
  endtask

  task automatic test_row_gap();
    drive_job({9{8'd1}}, {3{24'h010101}}, 5, 0, 1'b0, 1'b0, '0);
    checks += 3;
    if (done_edge - acc_edge != 22) begin failures++; $display("FAIL gap_latency got=%0d exp=22", done_edge - acc_edge); end
    if (gap_en != 0) begin failures++; $display("FAIL gap_sa_en got=%0d exp=0", gap_en); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL gap_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_drain_toggle();
    drive_job(rand_wgt(), rand_rows(), 0, 9, 1'b0, 1'b0, '0);
    checks += 4;
    if (unstable != 0) begin failures++; $display("FAIL toggle_res_data_stable got=%0d exp=0", unstable); end
    if (last_cnt != 1 || last_bad != 0) begin failures++; $display("FAIL toggle_res_last got=%0d/%0d exp=1/0", last_cnt, last_bad); end
    if (done_cnt != 1) begin failures++; $display("FAIL toggle_done_pulses got=%0d exp=1", done_cnt); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL toggle_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [W9-1:0] w2;
    int first_done;
    w2 = rand_wgt();
    drive_job(rand_wgt(), rand_rows(), 0, 0, 1'b0, 1'b1, w2);
    first_done = done_edge;
    checks += 3;
    if (rdy_mid != 0) begin failures++; $display("FAIL b2b_holdoff_ready got=%0d exp=0", rdy_mid); end
    if (wgt_moved != 0) begin failures++; $display("FAIL b2b_sa_w_moved got=%0d exp=0", wgt_moved); end
    if (rdy_after !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_done got=%b exp=1", rdy_after); end
    drive_job(w2, rand_rows(), 0, 0, 1'b0, 1'b0, '0);
    checks += 2;
    if (acc_edge - first_done != 1) begin failures++; $display("FAIL b2b_accept_gap got=%0d exp=1", acc_edge - first_done); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int n;
    int res_seen;
    stub_mode = 1'b0;
    cmd_wgt = rand_wgt();
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    row_valid = 1'b1;
    row_data  = 24'h050403;
    n = 0;
    while (dbg_state != ST_FLUSH && n < 50) begin @(negedge clk); n++; end
    row_valid = 1'b0;
    checks++;
    if (dbg_state !== ST_FLUSH) begin failures++; $display("FAIL mid_reach_flush got=%0d exp=%0d", dbg_state, ST_FLUSH); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 4;
    if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL mid_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    if (res_valid !== 1'b0) begin failures++; $display("FAIL mid_res_valid got=%b exp=0", res_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
    if (sa_w !== '0) begin failures++; $display("FAIL mid_sa_w got=%h exp=0", sa_w); end
    res_seen = 0;
    repeat (12) begin @(negedge clk); if (res_valid !== 1'b0) res_seen++; end
    checks++;
    if (res_seen != 0) begin failures++; $display("FAIL mid_no_results got=%0d exp=0", res_seen); end
    drive_job(rand_wgt(), rand_rows(), 0, 0, 1'b0, 1'b0, '0);
    checks += 2;
    if (exp_q.size() != 0) begin failures++; $display("FAIL mid_fresh_leftover got=%0d exp=0", exp_q.size()); end
    if (done_edge - acc_edge != 17) begin failures++; $display("FAIL mid_fresh_latency got=%0d exp=17", done_edge - acc_edge); end
  endtask

`ifdef TPU_JOB_CTRL_PERF_EN
  task automatic test_perf();
    drive_job({9{8'd1}}, {3{24'h010101}}, 5, 4, 1'b0, 1'b0, '0);
    checks += 2;
    if (stall_at_done !== 16'd9) begin failures++; $display("FAIL perf_stall_cnt got=%0d exp=9", stall_at_done); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL perf_leftover got=%0d exp=0", exp_q.size()); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_wgt = '0;
    row_valid = 1'b0; row_data = '0; res_ready = 1'b0;
    stub_mode = 1'b0; cur_wgt = '0;
    test_reset();
    test_ones();
    test_stub();
    test_row_gap();
    test_drain_toggle();
    test_back_to_back();
    test_reset_mid();
`ifdef TPU_JOB_CTRL_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
